// File: rtl/reg_dump_sequencer_pkg.sv
// Shared definitions for the halt-time register viewer.
//   state_t   : sequencer states (idle / fetch a word / show it)
//   SEG_BLANK : active-low 7-segment pattern with every segment off
//   REG_IDX_W : width of a register index on the bank read port
package reg_dump_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         REG_IDX_W = 5;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to 7-segment glyph decoder, purely combinational.
//   nibble : 4-bit value 0..F
//   seg    : active-low segments, bit order {g,f,e,d,c,b,a}
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/reg_dump_sequencer.sv
// Halt-time register viewer. While hlt is high it walks register indices
// 0..NUM_REGS-1 on the bank's read port, captures each word and shows the
// index and the low byte of the word on two pairs of 7-segment digits.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   hlt         : CPU halted, enables scanning (level)
//   auto_mode   : 1 = advance when the dwell time expires
//   step        : manual advance, rising edge counts
//   rb_data     : combinational read data for rb_addr
//   rb_addr     : register index presented to the bank
//   disp_valid  : disp_addr/disp_value hold a captured register
//   disp_addr   : index of the displayed register
//   disp_value  : captured register word
//   seg_addr    : two hex digits of disp_addr, [13:7] high digit
//   seg_val     : two hex digits of disp_value[7:0], [13:7] high digit
//   pass_done   : one-cycle pulse when the index wraps back to 0
module reg_dump_sequencer
  import reg_dump_sequencer_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000000,
  parameter int NUM_REGS     = 32,
  parameter int DATA_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hlt,
  input  logic                 auto_mode,
  input  logic                 step,
  input  logic [DATA_W-1:0]    rb_data,
  output logic [REG_IDX_W-1:0] rb_addr,
  output logic                 disp_valid,
  output logic [REG_IDX_W-1:0] disp_addr,
  output logic [DATA_W-1:0]    disp_value,
  output logic [13:0]          seg_addr,
  output logic [13:0]          seg_val,
  output logic                 pass_done
);

  localparam int                   CNT_W    = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

  state_t                 state_reg, state_next;
  logic [REG_IDX_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   step_d_reg;
  logic                   disp_valid_reg, disp_valid_next;
  logic [REG_IDX_W-1:0]   disp_addr_reg, disp_addr_next;
  logic [DATA_W-1:0]      disp_value_reg, disp_value_next;
  logic                   pass_done_reg, pass_done_next;

  logic step_edge;
  logic advance;

  assign step_edge = step & ~step_d_reg;
  // Dwell expiry and a step edge in the same cycle still give one advance.
  assign advance   = (auto_mode && (cnt_reg == '0)) || step_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      step_d_reg     <= 1'b0;
      disp_valid_reg <= 1'b0;
      disp_addr_reg  <= '0;
      disp_value_reg <= '0;
      pass_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      step_d_reg     <= step;
      disp_valid_reg <= disp_valid_next;
      disp_addr_reg  <= disp_addr_next;
      disp_value_reg <= disp_value_next;
      pass_done_reg  <= pass_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    disp_valid_next = disp_valid_reg;
    disp_addr_next  = disp_addr_reg;
    disp_value_next = disp_value_reg;
    pass_done_next  = 1'b0;
    rb_addr         = idx_reg;

    if (!hlt) begin
      // Leaving halt from any state clears everything, as at reset.
      state_next      = ST_IDLE;
      idx_next        = '0;
      cnt_next        = '0;
      disp_valid_next = 1'b0;
      disp_addr_next  = '0;
      disp_value_next = '0;
      if (state_reg == ST_IDLE) begin
        rb_addr = '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          rb_addr    = '0;
          state_next = ST_FETCH;
          idx_next   = '0;
        end
        ST_FETCH: begin
          disp_value_next = rb_data;
          disp_addr_next  = idx_reg;
          disp_valid_next = 1'b1;
          cnt_next        = CNT_LOAD;
          state_next      = ST_SHOW;
        end
        ST_SHOW: begin
          if (advance) begin
            // Display keeps the previous word until the next capture.
            idx_next       = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
            pass_done_next = (idx_reg == LAST_IDX);
            state_next     = ST_FETCH;
          end else if (auto_mode) begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign disp_valid = disp_valid_reg;
  assign disp_addr  = disp_addr_reg;
  assign disp_value = disp_value_reg;
  assign pass_done  = pass_done_reg;

  // Digit nibbles: 0 = value low, 1 = value high, 2 = index low, 3 = index high.
  logic [3:0] nib   [4];
  logic [6:0] glyph [4];

  assign nib[0] = disp_value_reg[3:0];
  assign nib[1] = disp_value_reg[7:4];
  assign nib[2] = disp_addr_reg[3:0];
  assign nib[3] = {3'b000, disp_addr_reg[REG_IDX_W-1]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      hex_to_7seg u_hex (
        .nibble (nib[gi]),
        .seg    (glyph[gi])
      );
    end
  endgenerate

  assign seg_val  = disp_valid_reg ? {glyph[1], glyph[0]} : {SEG_BLANK, SEG_BLANK};
  assign seg_addr = disp_valid_reg ? {glyph[3], glyph[2]} : {SEG_BLANK, SEG_BLANK};

endmodule
